pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline control unit for the Y86-64 five-stage core. It detects load/use hazards, `ret` hazards, branch mispredictions and exceptional status. From these it drives the per-stage stall and bubble controls and the condition-code write enable. It also runs a RUN/HALT status machine with performance counters. It sits beside the F/D/E/M/W pipeline registers and the decode/write-back stage, observing stage state and controlling the pipeline registers around them.

## Interface
Parameters:
- `CNT_W`, 32: width of each performance counter.

Ports:
- `clk_i`  in  1  single clock; all state updates on rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `D_icode_i`  in  4  icode in D register.
- `d_srcA_i`, `d_srcB_i`  in  4 each  decode source registers (`RNONE` = 4'hF when unused).
- `E_icode_i`  in  4  icode in E register.
- `E_dstM_i`  in  4  memory destination in E register.
- `e_Cnd_i`  in  1  branch condition computed in execute.
- `M_icode_i`  in  4  icode in M register.
- `m_stat_i`  in  4  status out of memory stage.
- `W_icode_i`, `W_stat_i`  in  4 each  icode and status in W register.
- `F_stall_o`, `D_stall_o`, `D_bubble_o`, `E_bubble_o`, `M_bubble_o`, `W_stall_o`  out  1 each  pipeline register controls.
- `set_cc_o`  out  1  CC write enable.
- `halted_o`  out  1  machine stopped.
- `cpu_stat_o`  out  4  latched final status.
- `cycle_cnt_o`, `instr_cnt_o`, `lu_cnt_o`, `misp_cnt_o`, `ret_cnt_o`  out  CNT_W each  performance counters.

## Operation
Hazard terms, combinational:
- `loaduse` = `E_icode` ∈ {`IMRMOVQ`, `IPOPQ`} ∧ `E_dstM` ≠ `RNONE` ∧ `E_dstM` ∈ {`d_srcA`, `d_srcB`}.
- `ret` = `IRET` ∈ {`D_icode`, `E_icode`, `M_icode`}.
- `misp` = `E_icode` = `IJXX` ∧ ¬`e_Cnd`.
- `exc(s)` = s ∈ {`SADR`, `SINS`, `SHLT`}.

RUN-state outputs:
- `F_stall` = loaduse ∨ ret.
- `D_stall` = loaduse.
- `D_bubble` = misp ∨ (ret ∧ ¬loaduse).
- `E_bubble` = misp ∨ loaduse.
- `M_bubble` = exc(`m_stat`) ∨ exc(`W_stat`).
- `W_stall` = exc(`W_stat`).
- `set_cc` = `E_icode` = `IOPQ` ∧ ¬exc(`m_stat`) ∧ ¬exc(`W_stat`).
- Never assert stall and bubble on the same register. `D_stall` has priority over `D_bubble`, which is already guaranteed by the term above.

HALT-state outputs:
- `F_stall` = `D_stall` = `W_stall` = 1.
- All bubbles = 0; `set_cc` = 0.

FSM (2 states):
- Reset → RUN.
- RUN → HALT when exc(`W_stat_i`); `cpu_stat` ← `W_stat_i` on the same edge.
- HALT is absorbing; only `rst_i` exits it.

Counters (free-running, saturate at all-ones, no wrap):
- cycle: +1 every RUN cycle.
- instr: +1 when RUN ∧ `W_stat` = `SAOK` ∧ `W_icode` ≠ `INOP`. Bubbles and explicit nops are not counted.
- lu: +1 per RUN cycle with loaduse.
- misp: +1 per RUN cycle with misp.
- ret: +1 per RUN cycle with ret ∧ ¬loaduse, i.e. one count per ret bubble cycle.
- No counter changes in HALT.

## Timing
- Stall, bubble and `set_cc` outputs are combinational from inputs and state: zero latency, same cycle.
- `halted_o`, `cpu_stat_o` and the counters are registered. Status exception in W at cycle t → `W_stall` = 1 in t; `halted_o` = 1 and `cpu_stat_o` valid from t+1.
- Reset values: state RUN, `halted_o` = 0, `cpu_stat_o` = `SAOK` (1), all counters 0.
- Combinational outputs during reset follow RUN equations on current inputs.
- `rst_i` in HALT returns to RUN next cycle. `rst_i` has priority over all counter and FSM updates in the same cycle.
- loaduse ∧ ret in the same cycle: load/use wins, giving `D_stall` = 1, `E_bubble` = 1, `D_bubble` = 0.
- misp ∧ ret: misp term holds, so `D_bubble` = `E_bubble` = 1.

## Structure
- icode, stat and register constants (`IRET`, `IJXX`, `IOPQ`, `IMRMOVQ`, `IPOPQ`, `INOP`, `RNONE`, `SAOK`, `SHLT`, `SADR`, `SINS`) and `NIBBLE` come from `define.v`.
- Add the FSM state encoding `PC_RUN`/`PC_HALT` to `define.v`.
- One sub-module, `sat_counter`, parameterised by `CNT_W`, with `inc` and synchronous clear; instantiated five times.

## Test plan
- Load/use: `E_icode` = 5, `E_dstM` = 3, `d_srcB` = 3 → `F_stall` = `D_stall` = `E_bubble` = 1, `D_bubble` = 0; `lu_cnt` increments by 1.
- Mispredict: `E_icode` = 7, `e_Cnd` = 0 → `D_bubble` = `E_bubble` = 1, `F_stall` = 0. With `e_Cnd` = 1 → all controls 0.
- Ret drain: `IRET` walks D→E→M over 3 cycles → `F_stall` = `D_bubble` = 1 each cycle; `ret_cnt` = 3.
- Halt: `W_stat` = 2 (SHLT) at cycle t → `W_stall` = `M_bubble` = 1 at t; `halted_o` = 1 and `cpu_stat_o` = 2 at t+1; counters frozen. `rst_i` → `halted_o` = 0, `cpu_stat_o` = 1, counters 0.
- `set_cc` suppression: `E_icode` = 6 with `m_stat` = 3 (SADR) → `set_cc` = 0, `M_bubble` = 1.
- Saturation: `CNT_W` = 4, run 20 cycles → `cycle_cnt` holds 15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - Y86-64 icode/stat/register constants and pipe_ctrl state encoding
package pipe_ctrl_pkg;

    localparam int NIBBLE = 4;

    localparam logic [NIBBLE-1:0] INOP    = 4'h1;
    localparam logic [NIBBLE-1:0] IMRMOVQ = 4'h5;
    localparam logic [NIBBLE-1:0] IOPQ    = 4'h6;
    localparam logic [NIBBLE-1:0] IJXX    = 4'h7;
    localparam logic [NIBBLE-1:0] IRET    = 4'h9;
    localparam logic [NIBBLE-1:0] IPOPQ   = 4'hB;

    localparam logic [NIBBLE-1:0] RNONE   = 4'hF;

    localparam logic [NIBBLE-1:0] SAOK    = 4'h1;
    localparam logic [NIBBLE-1:0] SHLT    = 4'h2;
    localparam logic [NIBBLE-1:0] SADR    = 4'h3;
    localparam logic [NIBBLE-1:0] SINS    = 4'h4;

    typedef enum logic {
        PC_RUN  = 1'b0,
        PC_HALT = 1'b1
    } pc_state_e;

    function automatic logic is_exc(input logic [NIBBLE-1:0] s);
        return (s == SADR) || (s == SINS) || (s == SHLT);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - Y86-64 hazard control, RUN/HALT status machine and performance counters
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [3:0]       D_icode_i,
    input  logic [3:0]       d_srcA_i,
    input  logic [3:0]       d_srcB_i,
    input  logic [3:0]       E_icode_i,
    input  logic [3:0]       E_dstM_i,
    input  logic             e_Cnd_i,
    input  logic [3:0]       M_icode_i,
    input  logic [3:0]       m_stat_i,
    input  logic [3:0]       W_icode_i,
    input  logic [3:0]       W_stat_i,
    output logic             F_stall_o,
    output logic             D_stall_o,
    output logic             D_bubble_o,
    output logic             E_bubble_o,
    output logic             M_bubble_o,
    output logic             W_stall_o,
    output logic             set_cc_o,
    output logic             halted_o,
    output logic [3:0]       cpu_stat_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] instr_cnt_o,
    output logic [CNT_W-1:0] lu_cnt_o,
    output logic [CNT_W-1:0] misp_cnt_o,
    output logic [CNT_W-1:0] ret_cnt_o
);

    pc_state_e  state_q, state_d;
    logic       halted_q, halted_d;
    logic [3:0] cpu_stat_q, cpu_stat_d;

    logic loaduse, ret_haz, misp, m_exc, w_exc;
    logic run, use_run_eq;

    always_comb begin
        loaduse = ((E_icode_i == IMRMOVQ) || (E_icode_i == IPOPQ))
                  && (E_dstM_i != RNONE)
                  && ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
        ret_haz = (D_icode_i == IRET) || (E_icode_i == IRET) || (M_icode_i == IRET);
        misp    = (E_icode_i == IJXX) && !e_Cnd_i;
        m_exc   = is_exc(m_stat_i);
        w_exc   = is_exc(W_stat_i);
    end

    assign run = (state_q == PC_RUN);
    // While reset is held the pipeline sees RUN behaviour even if the state is still HALT.
    assign use_run_eq = run || rst_i;

    always_comb begin
        F_stall_o  = 1'b1;
        D_stall_o  = 1'b1;
        D_bubble_o = 1'b0;
        E_bubble_o = 1'b0;
        M_bubble_o = 1'b0;
        W_stall_o  = 1'b1;
        set_cc_o   = 1'b0;
        if (use_run_eq) begin
            F_stall_o  = loaduse || ret_haz;
            D_stall_o  = loaduse;
            D_bubble_o = misp || (ret_haz && !loaduse);
            E_bubble_o = misp || loaduse;
            M_bubble_o = m_exc || w_exc;
            W_stall_o  = w_exc;
            set_cc_o   = (E_icode_i == IOPQ) && !m_exc && !w_exc;
        end
    end

    always_comb begin
        state_d    = state_q;
        halted_d   = halted_q;
        cpu_stat_d = cpu_stat_q;
        if (run && w_exc) begin
            state_d    = PC_HALT;
            halted_d   = 1'b1;
            cpu_stat_d = W_stat_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= PC_RUN;
            halted_q   <= 1'b0;
            cpu_stat_q <= SAOK;
        end else begin
            state_q    <= state_d;
            halted_q   <= halted_d;
            cpu_stat_q <= cpu_stat_d;
        end
    end

    assign halted_o   = halted_q;
    assign cpu_stat_o = cpu_stat_q;

    sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .inc_i (run),
        .cnt_o (cycle_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_instr_cnt (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .inc_i (run && (W_stat_i == SAOK) && (W_icode_i != INOP)),
        .cnt_o (instr_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_lu_cnt (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .inc_i (run && loaduse),
        .cnt_o (lu_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_misp_cnt (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .inc_i (run && misp),
        .cnt_o (misp_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_ret_cnt (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .inc_i (run && ret_haz && !loaduse),
        .cnt_o (ret_cnt_o)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, m_stat, W_icode, W_stat;
    logic        e_Cnd;

    logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted;
    logic [3:0]  cpu_stat;
    logic [31:0] cycle_cnt, instr_cnt, lu_cnt, misp_cnt, ret_cnt;

    logic        s_F_stall, s_D_stall, s_D_bubble, s_E_bubble, s_M_bubble, s_W_stall, s_set_cc, s_halted;
    logic [3:0]  s_cpu_stat;
    logic [3:0]  s_cycle_cnt, s_instr_cnt, s_lu_cnt, s_misp_cnt, s_ret_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.CNT_W(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .D_icode_i(D_icode), .d_srcA_i(d_srcA), .d_srcB_i(d_srcB),
        .E_icode_i(E_icode), .E_dstM_i(E_dstM), .e_Cnd_i(e_Cnd),
        .M_icode_i(M_icode), .m_stat_i(m_stat), .W_icode_i(W_icode), .W_stat_i(W_stat),
        .F_stall_o(F_stall), .D_stall_o(D_stall), .D_bubble_o(D_bubble), .E_bubble_o(E_bubble),
        .M_bubble_o(M_bubble), .W_stall_o(W_stall), .set_cc_o(set_cc),
        .halted_o(halted), .cpu_stat_o(cpu_stat),
        .cycle_cnt_o(cycle_cnt), .instr_cnt_o(instr_cnt), .lu_cnt_o(lu_cnt),
        .misp_cnt_o(misp_cnt), .ret_cnt_o(ret_cnt)
    );

    pipe_ctrl #(.CNT_W(4)) dut_sat (
        .clk_i(clk), .rst_i(rst),
        .D_icode_i(D_icode), .d_srcA_i(d_srcA), .d_srcB_i(d_srcB),
        .E_icode_i(E_icode), .E_dstM_i(E_dstM), .e_Cnd_i(e_Cnd),
        .M_icode_i(M_icode), .m_stat_i(m_stat), .W_icode_i(W_icode), .W_stat_i(W_stat),
        .F_stall_o(s_F_stall), .D_stall_o(s_D_stall), .D_bubble_o(s_D_bubble), .E_bubble_o(s_E_bubble),
        .M_bubble_o(s_M_bubble), .W_stall_o(s_W_stall), .set_cc_o(s_set_cc),
        .halted_o(s_halted), .cpu_stat_o(s_cpu_stat),
        .cycle_cnt_o(s_cycle_cnt), .instr_cnt_o(s_instr_cnt), .lu_cnt_o(s_lu_cnt),
        .misp_cnt_o(s_misp_cnt), .ret_cnt_o(s_ret_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ctrl vector order: F_stall D_stall D_bubble E_bubble M_bubble W_stall set_cc
    task automatic chk_ctrl(input string tag, input logic [6:0] exp);
        chk(tag, {25'd0, F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc}, {25'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        D_icode = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF;
        E_icode = 4'h1; E_dstM = 4'hF; e_Cnd = 1'b1;
        M_icode = 4'h1; m_stat = 4'h1; W_icode = 4'h1; W_stat = 4'h1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_cpu_stat", {28'd0, cpu_stat}, 32'd1);
        chk("rst_cycle", cycle_cnt, 32'd0);
        chk("rst_lu", lu_cnt, 32'd0);
        rst = 1'b0;
        #1;
        chk_ctrl("idle_ctrl", 7'b0000000);

        // load/use on srcB
        E_icode = 4'h5; E_dstM = 4'h3; d_srcB = 4'h3;
        #1;
        chk_ctrl("loaduse_ctrl", 7'b1101000);
        tick();
        chk("loaduse_cnt", lu_cnt, 32'd1);

        // load/use together with ret: load/use wins
        D_icode = 4'h9;
        #1;
        chk_ctrl("lu_ret_ctrl", 7'b1101000);
        tick();

        // mrmovq with dstM = RNONE never stalls, even though srcA is RNONE
        D_icode = 4'h1; E_dstM = 4'hF;
        #1;
        chk_ctrl("lu_rnone_ctrl", 7'b0000000);
        tick();

        // mispredicted jump
        idle();
        E_icode = 4'h7; e_Cnd = 1'b0;
        #1;
        chk_ctrl("misp_ctrl", 7'b0011000);
        tick();
        e_Cnd = 1'b1;
        #1;
        chk_ctrl("jxx_taken_ctrl", 7'b0000000);
        tick();

        // misp and ret together
        e_Cnd = 1'b0; D_icode = 4'h9;
        #1;
        chk_ctrl("misp_ret_ctrl", 7'b1011000);
        tick();

        // ret draining D -> E -> M
        idle();
        D_icode = 4'h9;
        #1;
        chk_ctrl("ret_D_ctrl", 7'b1010000);
        tick();
        D_icode = 4'h1; E_icode = 4'h9;
        #1;
        chk_ctrl("ret_E_ctrl", 7'b1010000);
        tick();
        E_icode = 4'h1; M_icode = 4'h9;
        #1;
        chk_ctrl("ret_M_ctrl", 7'b1010000);
        tick();

        // opq in E with a real instruction retiring
        idle();
        E_icode = 4'h6; W_icode = 4'h6;
        #1;
        chk_ctrl("opq_setcc_ctrl", 7'b0000001);
        tick();

        // set_cc suppressed by memory-stage address error
        W_icode = 4'h1; m_stat = 4'h3;
        #1;
        chk_ctrl("setcc_supp_ctrl", 7'b0000100);
        tick();
        chk("pre_halt_cycle", cycle_cnt, 32'd11);
        chk("pre_halt_instr", instr_cnt, 32'd1);
        chk("pre_halt_lu", lu_cnt, 32'd2);
        chk("pre_halt_misp", misp_cnt, 32'd2);
        chk("pre_halt_ret", ret_cnt, 32'd4);

        // halt reaches W
        idle();
        W_icode = 4'h0; W_stat = 4'h2;
        #1;
        chk_ctrl("halt_t_ctrl", 7'b0000110);
        chk("halt_t_halted", {31'd0, halted}, 32'd0);
        tick();
        chk("halt_t1_halted", {31'd0, halted}, 32'd1);
        chk("halt_t1_stat", {28'd0, cpu_stat}, 32'd2);
        chk("halt_t1_cycle", cycle_cnt, 32'd12);
        chk("halt_t1_instr", instr_cnt, 32'd1);

        // HALT overrides hazards and freezes counters
        idle();
        E_icode = 4'h5; E_dstM = 4'h3; d_srcB = 4'h3;
        #1;
        chk_ctrl("halted_ctrl", 7'b1100010);
        tick();
        tick();
        chk("halted_cycle", cycle_cnt, 32'd12);
        chk("halted_lu", lu_cnt, 32'd2);
        chk("halted_stat", {28'd0, cpu_stat}, 32'd2);

        // reset from HALT: RUN equations apply while reset is held
        rst = 1'b1;
        #1;
        chk_ctrl("rst_in_halt_ctrl", 7'b1101000);
        tick();
        chk("post_rst_halted", {31'd0, halted}, 32'd0);
        chk("post_rst_stat", {28'd0, cpu_stat}, 32'd1);
        chk("post_rst_cycle", cycle_cnt, 32'd0);
        chk("post_rst_lu", lu_cnt, 32'd0);
        rst = 1'b0;
        idle();

        // saturation of the 4-bit instance
        for (int i = 0; i < 20; i++) tick();
        chk("sat_cycle4", {28'd0, s_cycle_cnt}, 32'd15);
        chk("wide_cycle", cycle_cnt, 32'd20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
